// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 select decoder among 16 requesters.
// Break-before-make: one dead GAP cycle between owners, optional hold timeout.
module decoder_select_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  addr,
  output logic        en,
  output logic [15:0] grant,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic             TO_ON    = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_ptr;
  logic [3:0]       w_ptr_nxt;
  logic [3:0]       r_addr;
  logic [3:0]       w_addr_nxt;
  logic             r_en;
  logic             w_en_nxt;
  logic [15:0]      r_grant;
  logic [15:0]      w_grant_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [3:0]       w_win;
  logic [3:0]       w_idx;
  logic             w_found;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_to;

  // Search req from ptr upward; the 4-bit index wraps 15 -> 0 on its own.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      w_idx = r_ptr + 4'(i);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_addr_nxt    = r_addr;
    w_en_nxt      = r_en;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_rel_done    = 1'b0;
    w_rel_drop    = 1'b0;
    w_rel_to      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_addr_nxt  = w_win;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_rel_done = done;
        w_rel_drop = !req[r_addr];
        w_rel_to   = TO_ON && (r_cnt == CNT_LAST);
        if (w_rel_done || w_rel_drop || w_rel_to) begin
          w_state_nxt   = GAP;
          w_en_nxt      = 1'b0;
          w_ptr_nxt     = r_addr + 4'd1;
          // Only a pure timer expiry is reported; coincident causes are silent.
          w_timeout_nxt = w_rel_to && !w_rel_done && !w_rel_drop;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase

    w_busy_nxt  = (w_state_nxt != IDLE);
    w_grant_nxt = w_en_nxt ? (16'd1 << w_addr_nxt) : 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_en      <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_addr    <= w_addr_nxt;
      r_en      <= w_en_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign addr    = r_addr;
  assign en      = r_en;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Self-checking bench for decoder_select_arbiter: directed vector table plus
// hand-written sequences for wrap-around, timeout, coincident release and reset.
module tb_decoder_select_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NVEC    = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  addr;
  logic        en;
  logic [15:0] grant;
  logic        busy;
  logic        timeout;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic        en;
    logic [3:0]  addr;
    logic [15:0] grant;
    logic        busy;
    logic        to;
  } vec_t;

  vec_t vecs [NVEC];

  decoder_select_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .addr    (addr),
    .en      (en),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  // addr is only meaningful while en=1, so it is compared then or when forced.
  task automatic checkOutput(input string name, input logic eEn, input logic [3:0] eAddr,
                             input logic [15:0] eGrant, input logic eBusy, input logic eTo,
                             input logic fullAddr);
    logic [22:0] gotV;
    logic [22:0] expV;
    logic [3:0]  cmpAddr;
    cmpAddr = (eEn || fullAddr) ? addr : eAddr;
    gotV = {en, cmpAddr, grant, busy, timeout};
    expV = {eEn, eAddr, eGrant, eBusy, eTo};
    checkCount++;
    if (gotV === expV) passCount++;
    else $display("[TB] FAIL %s: got en=%b addr=%0d grant=%h busy=%b timeout=%b, expected en=%b addr=%0d grant=%h busy=%b timeout=%b",
                  name, en, addr, grant, busy, timeout, eEn, eAddr, eGrant, eBusy, eTo);
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  initial begin
    int cycles;
    bit fell;

    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b1, 1'b0};
    vecs[2]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b1, 1'b0};
    vecs[3]  = '{16'h0001, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{16'h0001, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b1, 1'b0};
    vecs[6]  = '{16'h0001, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{16'h8001, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'h8001, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0};
    vecs[9]  = '{16'h8001, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0};
    vecs[10] = '{16'h8001, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16'h8001, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[12] = '{16'h8001, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b1, 1'b0};
    vecs[13] = '{16'h8001, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[14] = '{16'h8001, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[15] = '{16'h8001, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0};
    vecs[16] = '{16'h0001, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[17] = '{16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    vecs[18] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};

    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    #1;
    checkOutput("reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, fairness between 0 and 15, req drop, done in IDLE.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].grant,
                  vecs[i].busy, vecs[i].to, 1'b0);
    end

    // Wrap-around: release 14 so ptr=15, then 0 wins before 14.
    applyStimulus(16'h4000, 1'b0);
    checkOutput("wrap_g14", 1'b1, 4'd14, 16'h4000, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h4000, 1'b1);
    applyStimulus(16'h4001, 1'b0);
    applyStimulus(16'h4001, 1'b0);
    checkOutput("wrap_g0", 1'b1, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h4001, 1'b1);
    applyStimulus(16'h4001, 1'b0);
    applyStimulus(16'h4001, 1'b0);
    checkOutput("wrap_g14b", 1'b1, 4'd14, 16'h4000, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);

    // Timeout: requester 5 holds without done.
    applyStimulus(16'h0020, 1'b0);
    checkOutput("to_g5", 1'b1, 4'd5, 16'h0020, 1'b1, 1'b0, 1'b0);
    cycles = 1;
    fell   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'h0020, 1'b0);
      if (en) cycles++;
      else begin
        fell = 1'b1;
        break;
      end
    end
    checkValue("to_fell", int'(fell), 1);
    checkValue("to_len", cycles, TIMEOUT);
    checkOutput("to_pulse", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'h0020, 1'b0);
    checkOutput("to_idle", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0020, 1'b0);
    checkOutput("to_regrant5", 1'b1, 4'd5, 16'h0020, 1'b1, 1'b0, 1'b0);

    // Second expiry, then requester 6 shows ptr moved to 6.
    fell = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'h0020, 1'b0);
      if (!en) begin
        fell = 1'b1;
        break;
      end
    end
    checkValue("to2_fell", int'(fell), 1);
    applyStimulus(16'h0060, 1'b0);
    applyStimulus(16'h0060, 1'b0);
    checkOutput("ptr6_g6", 1'b1, 4'd6, 16'h0040, 1'b1, 1'b0, 1'b0);

    // done coincident with the last allowed cycle: one release, no pulse.
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(16'h0060, 1'b0);
    checkOutput("coinc_hold", 1'b1, 4'd6, 16'h0040, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0060, 1'b1);
    checkOutput("coinc_rel", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Move ptr to 9, grant 9, then reset asynchronously mid-grant.
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0100, 1'b0);
    checkOutput("pre_g8", 1'b1, 4'd8, 16'h0100, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0100, 1'b1);
    applyStimulus(16'h0300, 1'b0);
    applyStimulus(16'h0300, 1'b0);
    checkOutput("pre_g9", 1'b1, 4'd9, 16'h0200, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    applyStimulus(16'h0300, 1'b0);
    checkOutput("post_rst_g8", 1'b1, 4'd8, 16'h0100, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
